// File: rtl/tt3_sweep_capture_pkg.sv
// Shared types and constants for the 3-input truth-table sweep/capture block.
package tt3_pkg;

    localparam int ROW_W    = 3;
    localparam int NUM_ROWS = 8;
    localparam int TT_W     = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } tt3_state_t;

    // Tables are stored MSB-first, so row 0 lands in bit 7.
    function automatic logic [ROW_W-1:0] tt_bit_idx(input logic [ROW_W-1:0] row);
        return ROW_W'(NUM_ROWS - 1) - row;
    endfunction

endpackage

// File: rtl/tt3_sweep_capture_if.sv
// Bundle between the sweep/capture engine (master) and the block under test plus its controller (slave).
interface tt3_sweep_capture_if;
    import tt3_pkg::*;

    logic            start;
    logic            in1;
    logic            in2;
    logic            in3;
    logic            dut_out;
    logic            busy;
    logic            done;
    logic [TT_W-1:0] truth_table;
    logic            match;
    logic            unstable;

    modport master (
        input  start,
        input  dut_out,
        output in1,
        output in2,
        output in3,
        output busy,
        output done,
        output truth_table,
        output match,
        output unstable
    );

    modport slave (
        output start,
        output dut_out,
        input  in1,
        input  in2,
        input  in3,
        input  busy,
        input  done,
        input  truth_table,
        input  match,
        input  unstable
    );

endinterface

// File: rtl/tt3_sweep_capture_settle_timer.sv
// Per-row settle down-counter: flags the last and second-to-last cycle of each row window.
module tt3_settle_timer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_last_cycle,
    output logic o_penultimate_cycle
);

    localparam int               CNT_W  = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= RELOAD;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_last_cycle        = (r_cnt == '0);
    assign o_penultimate_cycle = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/tt3_sweep_capture.sv
// Drives all 8 input rows of a 3-input block, captures its output per row and compares to EXPECTED_TT.
// Optional dual-sample stability check enabled by defining TT3_STABILITY_CHECK_EN.
module tt3_sweep_capture
    import tt3_pkg::*;
#(
    parameter int              SETTLE_CYCLES = 4,
    parameter logic [TT_W-1:0] EXPECTED_TT   = 8'h7D
) (
    input  logic          clk,
    input  logic          rst,
    tt3_sweep_capture_if.master bus
);

`ifdef TT3_STABILITY_CHECK_EN
    if (SETTLE_CYCLES < 2) begin : g_bad_settle
        $error("tt3_sweep_capture: SETTLE_CYCLES must be >= 2 with the stability check");
    end
`else
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("tt3_sweep_capture: SETTLE_CYCLES must be >= 1");
    end
`endif

    tt3_state_t       r_state;
    logic [ROW_W-1:0] r_row;
    logic [TT_W-1:0]  r_cap;
    logic [TT_W-1:0]  r_tt;
    logic             r_busy;
    logic             r_done;
    logic             r_match;
    logic             r_unstable;

    logic             w_accept;
    logic             w_last;
    logic             w_pen;
    logic             w_row_end;
    logic             w_unst_next;
    logic [TT_W-1:0]  w_cap_next;

    assign w_accept  = (r_state == IDLE) && bus.start;
    assign w_row_end = (r_state == RUN) && w_last;

    tt3_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk                (clk),
        .rst                (rst),
        .i_load             (w_accept || w_row_end),
        .i_en               (r_state == RUN),
        .o_last_cycle       (w_last),
        .o_penultimate_cycle(w_pen)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_cap_next                    = r_cap;
        w_cap_next[tt_bit_idx(r_row)] = bus.dut_out;
    end

`ifdef TT3_STABILITY_CHECK_EN
    logic r_pen_sample;
    logic r_unst_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pen_sample <= 1'b0;
            r_unst_acc   <= 1'b0;
        end else if (w_accept) begin
            r_unst_acc <= 1'b0;
        end else if (r_state == RUN) begin
            if (w_pen) begin
                r_pen_sample <= bus.dut_out;
            end
            if (w_last && (bus.dut_out != r_pen_sample)) begin
                r_unst_acc <= 1'b1;
            end
        end
    end

    // Includes the row being closed this cycle so the final row counts too.
    assign w_unst_next = r_unst_acc || (w_last && (bus.dut_out != r_pen_sample));
`else
    logic w_unused_pen;
    assign w_unused_pen = w_pen;
    assign w_unst_next  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_row      <= '0;
            r_cap      <= '0;
            r_tt       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_match    <= 1'b0;
            r_unstable <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state    <= RUN;
                        r_busy     <= 1'b1;
                        r_row      <= '0;
                        r_cap      <= '0;
                        r_tt       <= '0;
                        r_match    <= 1'b0;
                        r_unstable <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_last) begin
                        r_cap <= w_cap_next;
                        if (r_row == ROW_W'(NUM_ROWS - 1)) begin
                            // Last row sampled: publish results and park stimulus at row 0.
                            r_state    <= DONE;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_row      <= '0;
                            r_tt       <= w_cap_next;
                            r_unstable <= w_unst_next;
                            r_match    <= (w_cap_next == EXPECTED_TT) && !w_unst_next;
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in1         = r_row[2];
    assign bus.in2         = r_row[1];
    assign bus.in3         = r_row[0];
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.truth_table = r_tt;
    assign bus.match       = r_match;
    assign bus.unstable    = r_unstable;

endmodule

// File: tb/tb_tt3_sweep_capture.sv
// Directed bench for tt3_sweep_capture: a behavioural 0x7D block drives dut_out; S=4 and short-S instances.
module tb_tt3_sweep_capture;
    import tt3_pkg::*;

    localparam int S_A = 4;
`ifdef TT3_STABILITY_CHECK_EN
    localparam int S_B = 2;
`else
    localparam int S_B = 1;
`endif

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic mode_zero = 1'b0;
    logic glitch    = 1'b0;
    int   n_cmp     = 0;
    int   n_err     = 0;

    tt3_sweep_capture_if bus_a ();
    tt3_sweep_capture_if bus_b ();

    // Behavioural 3-input block with function 0x7D, row k -> bit 7-k.
    function automatic logic ref_row_out(input logic [2:0] row);
        logic [7:0] t;
        t = 8'h7D;
        return t[7 - row];
    endfunction

    assign bus_a.dut_out = (mode_zero ? 1'b0 : ref_row_out({bus_a.in1, bus_a.in2, bus_a.in3})) ^ glitch;
    assign bus_b.dut_out = ref_row_out({bus_b.in1, bus_b.in2, bus_b.in3});

    tt3_sweep_capture #(.SETTLE_CYCLES(S_A), .EXPECTED_TT(8'h7D)) u_dut_a (
        .clk(clk),
        .rst(rst),
        .bus(bus_a.master)
    );

    tt3_sweep_capture #(.SETTLE_CYCLES(S_B), .EXPECTED_TT(8'h7D)) u_dut_b (
        .clk(clk),
        .rst(rst),
        .bus(bus_b.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full sweep on instance A; glitch_n is the edge index (0 = accepting edge) whose sample is corrupted.
    task automatic sweep_a(input logic [7:0] exp_tt, input logic exp_match, input logic exp_unst,
                           input int glitch_n, input bit poke_start);
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        check("accept_busy", bus_a.busy, 1);
        check("accept_tt_clear", bus_a.truth_table, 0);
        check("accept_match_clear", bus_a.match, 0);
        check("accept_unstable_clear", bus_a.unstable, 0);
        for (int n = 0; n < 8 * S_A; n++) begin
            check("row_order", {bus_a.in1, bus_a.in2, bus_a.in3}, n / S_A);
            check("run_busy_done", {bus_a.busy, bus_a.done}, 2'b10);
            glitch      = (n + 1 == glitch_n);
            bus_a.start = poke_start && (n == 3);
            tick();
        end
        glitch      = 1'b0;
        bus_a.start = 1'b0;
        check("done_latency", bus_a.done, 1);
        check("done_busy", bus_a.busy, 0);
        check("done_row", {bus_a.in1, bus_a.in2, bus_a.in3}, 0);
        check("done_tt", bus_a.truth_table, exp_tt);
        check("done_match", bus_a.match, exp_match);
        check("done_unstable", bus_a.unstable, exp_unst);
        if (poke_start) bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        check("done_one_cycle", {bus_a.busy, bus_a.done}, 2'b00);
        repeat (3) tick();
        check("no_queued_start", {bus_a.busy, bus_a.done}, 2'b00);
        check("tt_holds", bus_a.truth_table, exp_tt);
        check("match_holds", bus_a.match, exp_match);
    endtask

    initial begin
        bit saw_done;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_a_outputs", {bus_a.in1, bus_a.in2, bus_a.in3, bus_a.busy, bus_a.done,
                                bus_a.match, bus_a.unstable}, 0);
        check("rst_a_tt", bus_a.truth_table, 0);
        check("rst_b_outputs", {bus_b.busy, bus_b.done, bus_b.truth_table}, 0);
        rst = 1'b0;
        tick();

        // 0x7D block, nominal sweep
        sweep_a(8'h7D, 1'b1, 1'b0, -1, 1'b0);

        // Stuck-at-0 block
        mode_zero = 1'b1;
        sweep_a(8'h00, 1'b0, 1'b0, -1, 1'b0);
        mode_zero = 1'b0;

        // start pokes mid-sweep and in DONE are ignored
        sweep_a(8'h7D, 1'b1, 1'b0, -1, 1'b1);

        // Reset during row 3
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        repeat (3 * S_A + 1) tick();
        check("pre_rst_row3", {bus_a.in1, bus_a.in2, bus_a.in3}, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_row", {bus_a.in1, bus_a.in2, bus_a.in3}, 0);
        check("rst_mid_busy_done", {bus_a.busy, bus_a.done}, 2'b00);
        check("rst_mid_tt", bus_a.truth_table, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 8 * S_A + 4; i++) begin
            tick();
            if (bus_a.done === 1'b1) saw_done = 1'b1;
        end
        check("rst_mid_no_done", saw_done, 0);
        sweep_a(8'h7D, 1'b1, 1'b0, -1, 1'b0);

        // Short settle window instance
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        for (int n = 0; n < 8 * S_B; n++) begin
            check("b_row_order", {bus_b.in1, bus_b.in2, bus_b.in3}, n / S_B);
            check("b_run_busy_done", {bus_b.busy, bus_b.done}, 2'b10);
            tick();
        end
        check("b_done_latency", bus_b.done, 1);
        check("b_done_tt", bus_b.truth_table, 8'h7D);
        check("b_done_match", bus_b.match, 1);

`ifdef TT3_STABILITY_CHECK_EN
        // Glitch on the penultimate sample of row 5: edge 5*S + S - 1
        sweep_a(8'h7D, 1'b0, 1'b1, 5 * S_A + S_A - 1, 1'b0);
        sweep_a(8'h7D, 1'b1, 1'b0, -1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
